// File: rtl/multi_context_solver.sv
// Multi-context fail-soft alpha-beta negamax endgame solver: NCTX Othello jobs share one
// step engine in round-robin, each with its own frame stack, results leave through a tagged FIFO.
module multi_context_solver #(
  parameter int NCTX  = 8,
  parameter int DEPTH = 64,
  parameter int TAGW  = 8
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_player,
  input  logic [63:0]            in_opponent,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAGW-1:0]        out_tag,
  output logic signed [7:0]      out_score,
  output logic [31:0]            out_nodes,
  output logic                   out_status
);

  localparam int CW  = $clog2(NCTX);
  localparam int SPW = $clog2(DEPTH);
  localparam int FCW = $clog2(NCTX + 1);
  localparam logic signed [7:0] SCORE_MIN = -8'sd64;
  localparam logic signed [7:0] SCORE_MAX = 8'sd64;

  typedef enum logic [1:0] {CTX_IDLE, CTX_RUN, CTX_DONE} ctx_state_e;

  typedef struct packed {
    logic [63:0]       player;
    logic [63:0]       opponent;
    logic [63:0]       untried;
    logic signed [7:0] alpha;
    logic signed [7:0] beta;
    logic signed [7:0] best;
    logic              moved;
    logic              passed;
  } frame_t;

  typedef struct packed {
    logic [TAGW-1:0]   tag;
    logic signed [7:0] score;
    logic [31:0]       nodes;
    logic              status;
  } result_t;

  function automatic frame_t init_frame(input logic [63:0] p, input logic [63:0] o,
                                        input logic signed [7:0] a, input logic signed [7:0] b,
                                        input logic passed);
    frame_t f;
    f.player   = p;
    f.opponent = o;
    f.untried  = ~(p | o);
    f.alpha    = a;
    f.beta     = b;
    f.best     = SCORE_MIN;
    f.moved    = 1'b0;
    f.passed   = passed;
    return f;
  endfunction

  function automatic logic [5:0] lowest_sq(input logic [63:0] m);
    logic [5:0] r;
    logic       found;
    logic [5:0] idx;
    r = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx = 6'(i);
      if (m[idx] && !found) begin
        r = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] popcount(input logic [63:0] m);
    logic [6:0] c;
    logic [5:0] idx;
    c = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      idx = 6'(i);
      c = c + 7'(m[idx]);
    end
    return c;
  endfunction

  // Walk all eight rays from s; a ray contributes its opponent run only if it ends on a player disc.
  function automatic logic [63:0] flip_fn(input logic [63:0] p, input logic [63:0] o,
                                          input logic [5:0] s);
    logic [63:0] acc, line;
    logic        stop, hit;
    logic [5:0]  idx;
    int          r, c, dr, dc;
    acc = '0;
    for (int unsigned d = 0; d < 8; d++) begin
      case (d)
        0:       begin dr = -1; dc = -1; end
        1:       begin dr = -1; dc =  0; end
        2:       begin dr = -1; dc =  1; end
        3:       begin dr =  0; dc = -1; end
        4:       begin dr =  0; dc =  1; end
        5:       begin dr =  1; dc = -1; end
        6:       begin dr =  1; dc =  0; end
        default: begin dr =  1; dc =  1; end
      endcase
      line = '0;
      stop = 1'b0;
      hit  = 1'b0;
      r = int'(s[5:3]) + dr;
      c = int'(s[2:0]) + dc;
      for (int unsigned k = 0; k < 7; k++) begin
        if (!stop) begin
          if (r < 0 || r > 7 || c < 0 || c > 7) begin
            stop = 1'b1;
          end else begin
            idx = 6'(r * 8 + c);
            if (o[idx]) begin
              line[idx] = 1'b1;
            end else begin
              hit  = p[idx];
              stop = 1'b1;
            end
          end
          r = r + dr;
          c = c + dc;
        end
      end
      if (hit) acc = acc | line;
    end
    return acc;
  endfunction

  function automatic logic signed [7:0] terminal_score(input logic [63:0] p, input logic [63:0] o);
    logic [6:0] pc, oc;
    int         t;
    pc = popcount(p);
    oc = popcount(o);
    if (pc > oc)      t = 64 - 2 * int'(oc);
    else if (pc < oc) t = -64 + 2 * int'(pc);
    else              t = 0;
    return 8'(t);
  endfunction

  ctx_state_e          state_q  [NCTX];
  ctx_state_e          state_d  [NCTX];
  frame_t              top_q    [NCTX];
  frame_t              top_d    [NCTX];
  logic [SPW-1:0]      sp_q     [NCTX];
  logic [SPW-1:0]      sp_d     [NCTX];
  logic [31:0]         nodes_q  [NCTX];
  logic [31:0]         nodes_d  [NCTX];
  logic [TAGW-1:0]     tag_q    [NCTX];
  logic [TAGW-1:0]     tag_d    [NCTX];
  logic signed [7:0]   score_q  [NCTX];
  logic signed [7:0]   score_d  [NCTX];
  logic                status_q [NCTX];
  logic                status_d [NCTX];
  logic [CW-1:0]       cur_q, cur_d;

  frame_t              stack_q  [NCTX][DEPTH];
  logic                stack_we;
  logic [SPW-1:0]      stack_wr_sp;
  frame_t              stack_wr_data;

  result_t             fifo_q   [NCTX];
  result_t             fifo_wr_data;
  result_t             fifo_head;
  logic [CW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]      count_q, count_d;
  logic                fifo_push, fifo_pop, fifo_can_push;

  assign in_ready      = !iRESET && (state_q[cur_q] == CTX_IDLE);
  assign fifo_pop      = out_valid && out_ready;
  assign fifo_can_push = (count_q != FCW'(NCTX)) || fifo_pop;
  assign cur_d         = (cur_q == CW'(NCTX - 1)) ? '0 : cur_q + 1'b1;

  // The context in the current slot does one full frame read-modify-write this cycle;
  // only the top frame lives in registers, lower frames sit in the stack memory.
  always_comb begin
    frame_t            fr, nf, pf;
    logic [5:0]        sq;
    logic [63:0]       flips;
    logic              ret;
    logic signed [7:0] rv, v, nv;
    logic [SPW-1:0]    sp;

    state_d  = state_q;
    top_d    = top_q;
    sp_d     = sp_q;
    nodes_d  = nodes_q;
    tag_d    = tag_q;
    score_d  = score_q;
    status_d = status_q;
    stack_we      = 1'b0;
    stack_wr_sp   = '0;
    stack_wr_data = '0;
    fifo_push     = 1'b0;
    fifo_wr_data  = '0;

    fr    = top_q[cur_q];
    sp    = sp_q[cur_q];
    pf    = stack_q[cur_q][sp - 1'b1];
    nf    = fr;
    sq    = lowest_sq(fr.untried);
    flips = flip_fn(fr.player, fr.opponent, sq);
    ret   = 1'b0;
    rv    = '0;
    v     = '0;
    nv    = '0;

    case (state_q[cur_q])
      CTX_IDLE: begin
        if (in_valid && in_ready) begin
          top_d[cur_q]   = init_frame(in_player, in_opponent, SCORE_MIN, SCORE_MAX, 1'b0);
          sp_d[cur_q]    = '0;
          nodes_d[cur_q] = '0;
          tag_d[cur_q]   = in_tag;
          state_d[cur_q] = CTX_RUN;
        end
      end
      CTX_RUN: begin
        if (fr.alpha >= fr.beta) begin
          ret = 1'b1;
          rv  = fr.best;
        end else if (fr.untried != '0) begin
          nf.untried[sq] = 1'b0;
          top_d[cur_q]   = nf;
          if (flips != '0) begin
            nf.moved = 1'b1;
            if (sp == SPW'(DEPTH - 1)) begin
              score_d[cur_q]  = '0;
              status_d[cur_q] = 1'b1;
              state_d[cur_q]  = CTX_DONE;
            end else begin
              stack_we      = 1'b1;
              stack_wr_sp   = sp;
              stack_wr_data = nf;
              top_d[cur_q]  = init_frame(fr.opponent ^ flips, (fr.player ^ flips) | (64'd1 << sq),
                                         -fr.beta, -fr.alpha, 1'b0);
              sp_d[cur_q]   = sp + 1'b1;
              nodes_d[cur_q] = (nodes_q[cur_q] == '1) ? nodes_q[cur_q] : nodes_q[cur_q] + 1'b1;
            end
          end
        end else if (fr.moved) begin
          ret = 1'b1;
          rv  = fr.best;
        end else if (fr.passed) begin
          ret = 1'b1;
          rv  = terminal_score(fr.player, fr.opponent);
        end else begin
          top_d[cur_q] = init_frame(fr.opponent, fr.player, -fr.beta, -fr.alpha, 1'b1);
        end

        if (ret) begin
          v  = fr.passed ? -rv : rv;
          nv = -v;
          if (sp == '0) begin
            score_d[cur_q]  = v;
            status_d[cur_q] = 1'b0;
            state_d[cur_q]  = CTX_DONE;
          end else begin
            if (nv > pf.best)  pf.best  = nv;
            if (nv > pf.alpha) pf.alpha = nv;
            top_d[cur_q] = pf;
            sp_d[cur_q]  = sp - 1'b1;
          end
        end
      end
      CTX_DONE: begin
        if (fifo_can_push) begin
          fifo_push      = 1'b1;
          fifo_wr_data   = '{tag: tag_q[cur_q], score: score_q[cur_q],
                             nodes: nodes_q[cur_q], status: status_q[cur_q]};
          state_d[cur_q] = CTX_IDLE;
        end
      end
      default: state_d[cur_q] = CTX_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == CW'(NCTX - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == CW'(NCTX - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (fifo_push && !fifo_pop)      count_d = count_q + 1'b1;
    else if (!fifo_push && fifo_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    top_q    <= top_d;
    sp_q     <= sp_d;
    nodes_q  <= nodes_d;
    tag_q    <= tag_d;
    score_q  <= score_d;
    status_q <= status_d;
    if (iRESET) begin
      state_q  <= '{default: CTX_IDLE};
      cur_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (stack_we) stack_q[cur_q][stack_wr_sp] <= stack_wr_data;
    if (fifo_push) fifo_q[wr_ptr_q] <= fifo_wr_data;
  end

  assign fifo_head  = fifo_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_tag    = out_valid ? fifo_head.tag    : '0;
  assign out_score  = out_valid ? fifo_head.score  : '0;
  assign out_nodes  = out_valid ? fifo_head.nodes  : '0;
  assign out_status = out_valid ? fifo_head.status : 1'b0;

endmodule

// File: tb/tb_multi_context_solver.sv
// Directed bench for multi_context_solver: hand-computed positions, ordering, backpressure,
// stack overflow on a shallow instance, and reset during a search.
module tb_multi_context_solver;
  localparam int NCTX = 8;
  localparam int TAGW = 8;

  logic            iCLOCK;
  logic            iRESET;
  logic            in_valid, in_ready, out_valid, out_ready, out_status;
  logic [63:0]     in_player, in_opponent;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [7:0]      out_score;
  logic [31:0]     out_nodes;

  logic            ov_in_valid, ov_in_ready, ov_out_valid, ov_out_ready, ov_out_status;
  logic [63:0]     ov_in_player, ov_in_opponent;
  logic [TAGW-1:0] ov_in_tag, ov_out_tag;
  logic [7:0]      ov_out_score;
  logic [31:0]     ov_out_nodes;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  multi_context_solver #(.NCTX(NCTX), .DEPTH(64), .TAGW(TAGW)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_player(in_player), .in_opponent(in_opponent), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_score(out_score), .out_nodes(out_nodes), .out_status(out_status)
  );

  multi_context_solver #(.NCTX(NCTX), .DEPTH(2), .TAGW(TAGW)) dut_ovf (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .in_valid(ov_in_valid), .in_ready(ov_in_ready),
    .in_player(ov_in_player), .in_opponent(ov_in_opponent), .in_tag(ov_in_tag),
    .out_valid(ov_out_valid), .out_ready(ov_out_ready),
    .out_tag(ov_out_tag), .out_score(ov_out_score), .out_nodes(ov_out_nodes),
    .out_status(ov_out_status)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;
  always @(posedge iCLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] low_mask(input int n);
    logic [63:0] one;
    one = 64'd1;
    return (n >= 64) ? '1 : ((one << n) - 64'd1);
  endfunction

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic send_job(input logic [63:0] p, input logic [63:0] o, input logic [TAGW-1:0] t,
                          output bit acc, output int acc_cyc);
    int n;
    in_player = p; in_opponent = o; in_tag = t; in_valid = 1'b1;
    n = 0;
    acc_cyc = 0;
    while (!in_ready && n < 300) begin
      @(posedge iCLOCK); #1; n++;
    end
    acc = in_ready;
    if (acc) begin
      @(posedge iCLOCK); #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int budget, output logic [TAGW-1:0] t, output logic [7:0] sc,
                            output logic [31:0] nd, output logic st, output bit got,
                            output int rcv_cyc);
    int n;
    out_ready = 1'b1;
    n = 0;
    t = '0; sc = '0; nd = '0; st = 1'b0; rcv_cyc = 0;
    while (!out_valid && n < budget) begin
      @(posedge iCLOCK); #1; n++;
    end
    got = out_valid;
    if (got) begin
      t = out_tag; sc = out_score; nd = out_nodes; st = out_status; rcv_cyc = cyc;
      @(posedge iCLOCK); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    bit              acc, got, seen_ready, stale, dup;
    int              t_acc, t_rcv, acc_count, idx, n;
    logic [TAGW-1:0] r_tag, first_tag;
    logic [7:0]      r_score, first_score;
    logic [31:0]     r_nodes;
    logic            r_st;
    logic [15:0]     seen;

    in_valid = 0; in_player = '0; in_opponent = '0; in_tag = '0; out_ready = 0;
    ov_in_valid = 0; ov_in_player = '0; ov_in_opponent = '0; ov_in_tag = '0; ov_out_ready = 0;
    iRESET = 1'b1;
    repeat (3) @(posedge iCLOCK);
    #1;
    check("reset_in_ready", 64'(in_ready), 0);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_out_tag", 64'(out_tag), 0);
    check("reset_out_score", 64'(out_score), 0);
    check("reset_out_nodes", 64'(out_nodes), 0);
    check("reset_out_status", 64'(out_status), 0);
    iRESET = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 1);

    // Full board draw: pass then game end, two steps.
    send_job(64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 8'h11, acc, t_acc);
    check("draw_accept", 64'(acc), 1);
    get_result(200, r_tag, r_score, r_nodes, r_st, got, t_rcv);
    check("draw_got", 64'(got), 1);
    check("draw_tag", 64'(r_tag), 64'h11);
    check("draw_score", 64'(r_score), 64'h00);
    check("draw_nodes", 64'(r_nodes), 0);
    check("draw_status", 64'(r_st), 0);
    check("draw_latency_ok", 64'((t_rcv - t_acc) <= 3 * NCTX + 3), 1);

    // One empty at sq0, player flips sq1 and takes the whole board.
    send_job(64'hFFFFFFFFFFFFFFFC, 64'h2, 8'h22, acc, t_acc);
    get_result(300, r_tag, r_score, r_nodes, r_st, got, t_rcv);
    check("one_empty_tag", 64'(r_tag), 64'h22);
    check("one_empty_score", 64'(r_score), 64'h40);
    check("one_empty_nodes", 64'(r_nodes), 1);
    check("one_empty_status", 64'(r_st), 0);

    // Side to move has a lone disc and must pass; opponent then fills the board: -64.
    send_job(64'h2, 64'hFFFFFFFFFFFFFFFC, 8'h33, acc, t_acc);
    get_result(300, r_tag, r_score, r_nodes, r_st, got, t_rcv);
    check("pass_first_tag", 64'(r_tag), 64'h33);
    check("pass_first_score", 64'(r_score), 64'hC0);
    check("pass_first_nodes", 64'(r_nodes), 1);

    // Tag 0: 10 empties, no legal moves for either side (22 steps), 54 vs 0 -> +64.
    // Tags 1..7: full boards with 32+4k player discs -> score 8k.
    send_job(64'hFFFFFFFFFFFFFC00, 64'h0, 8'h00, acc, t_acc);
    for (int k = 1; k < NCTX; k++)
      send_job(low_mask(32 + 4 * k), ~low_mask(32 + 4 * k), 8'(k), acc, t_acc);
    for (int i = 0; i < NCTX; i++) begin
      get_result(600, r_tag, r_score, r_nodes, r_st, got, t_rcv);
      check("ooo_got", 64'(got), 1);
      check("ooo_tag", 64'(r_tag), (i < NCTX - 1) ? 64'(i + 1) : 64'h0);
      check("ooo_score", 64'(r_score), (i < NCTX - 1) ? 64'(8 * (i + 1)) : 64'h40);
    end

    // Backpressure: 2*NCTX quick jobs with the result port stalled.
    acc_count = 0;
    for (int i = 0; i < 2 * NCTX; i++) begin
      send_job(low_mask(32 + i % 8), ~low_mask(32 + i % 8), 8'(8'h40 + i), acc, t_acc);
      if (acc) acc_count++;
    end
    repeat (100) @(posedge iCLOCK);
    #1;
    check("bp_accepted", 64'(acc_count), 64'(2 * NCTX));
    seen_ready = 0;
    repeat (2 * NCTX) begin
      if (in_ready) seen_ready = 1;
      @(posedge iCLOCK); #1;
    end
    check("bp_ready_low", 64'(seen_ready), 0);
    check("bp_out_valid", 64'(out_valid), 1);
    check("bp_first_tag", 64'(out_tag), 64'h40);
    first_tag = out_tag;
    first_score = out_score;
    repeat (30) @(posedge iCLOCK);
    #1;
    check("bp_stable_tag", 64'(out_tag), 64'(first_tag));
    check("bp_stable_score", 64'(out_score), 64'(first_score));
    seen = '0;
    dup = 0;
    for (int i = 0; i < 2 * NCTX; i++) begin
      get_result(300, r_tag, r_score, r_nodes, r_st, got, t_rcv);
      idx = int'(r_tag) - 'h40;
      if (got && idx >= 0 && idx < 16) begin
        if (seen[idx]) dup = 1;
        seen[idx] = 1'b1;
        check("bp_score", 64'(r_score), 64'(2 * (idx % 8)));
      end else begin
        check("bp_drain_got", 64'(got), 1);
      end
    end
    check("bp_all_once", {47'b0, dup, seen}, {47'b0, 1'b0, 16'hFFFF});
    repeat (4) @(posedge iCLOCK);
    #1;
    check("bp_empty_after", 64'(out_valid), 0);

    // Overflow: DEPTH=2 instance, root move at sq0 then child move at sq3 cannot be pushed.
    ov_in_player = 64'hFFFFFFFFFFFFFF94;
    ov_in_opponent = 64'h22;
    ov_in_tag = 8'h55;
    ov_in_valid = 1'b1;
    n = 0;
    while (!ov_in_ready && n < 100) begin
      @(posedge iCLOCK); #1; n++;
    end
    check("ovf_accept", 64'(ov_in_ready), 1);
    @(posedge iCLOCK); #1;
    ov_in_valid = 1'b0;
    n = 0;
    while (!ov_out_valid && n < 200) begin
      @(posedge iCLOCK); #1; n++;
    end
    check("ovf_valid", 64'(ov_out_valid), 1);
    check("ovf_tag", 64'(ov_out_tag), 64'h55);
    check("ovf_status", 64'(ov_out_status), 1);
    check("ovf_score", 64'(ov_out_score), 0);

    // Reset in the middle of the long job; nothing stale may appear afterwards.
    send_job(64'hFFFFFFFFFFFFFC00, 64'h0, 8'h77, acc, t_acc);
    repeat (40) @(posedge iCLOCK);
    #1;
    iRESET = 1'b1;
    @(posedge iCLOCK); #1;
    iRESET = 1'b0;
    check("mid_reset_out_valid", 64'(out_valid), 0);
    stale = 0;
    repeat (300) begin
      if (out_valid) stale = 1;
      @(posedge iCLOCK); #1;
    end
    check("mid_reset_no_stale", 64'(stale), 0);
    send_job(64'hFFFFFFFFFFFFFFFC, 64'h2, 8'h78, acc, t_acc);
    get_result(300, r_tag, r_score, r_nodes, r_st, got, t_rcv);
    check("post_reset_tag", 64'(r_tag), 64'h78);
    check("post_reset_score", 64'(r_score), 64'h40);
    check("post_reset_nodes", 64'(r_nodes), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
